// File: rtl/dmem_load_unit.sv
// dmem_load_unit: read-side load path for the data memory.
// Accepts one load at a time, fetches one word (or two for loads that
// straddle a word boundary), then returns the extended byte/half/word result
// with a one-cycle valid pulse. busy stalls the pipeline while a load is in flight.
module dmem_load_unit #(
    parameter int BYTE_AW = 11,
    parameter int WORD_AW = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic [BYTE_AW-1:0] load_addr,
    input  logic [2:0]         load_sel,
    output logic               req_ready,
    output logic               busy,
    output logic [WORD_AW-1:0] mem_RA,
    input  logic [31:0]        mem_RD_word,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               load_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_LO = 2'd1,
        READ_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [1:0]         off_q, off_d;
    logic [WORD_AW-1:0] mem_ra_q, mem_ra_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        load_data_q, load_data_d;

    logic split;
    logic illegal;

    // Shift the {hi,lo} pair down by the byte offset and extend the field.
    function automatic logic [31:0] extract(input logic [2:0]  sel,
                                            input logic [1:0]  off,
                                            input logic [63:0] pair);
        logic [31:0] f;
        f = 32'(pair >> {off, 3'b000});
        case (sel)
            3'b000:  extract = {{24{f[7]}}, f[7:0]};
            3'b100:  extract = {24'h0, f[7:0]};
            3'b001:  extract = {{16{f[15]}}, f[15:0]};
            3'b101:  extract = {16'h0, f[15:0]};
            3'b010:  extract = f;
            default: extract = '0;
        endcase
    endfunction

    // Decode the latched selector: split detection and illegal-encoding flag.
    always_comb begin
        split   = ((sel_q[1:0] == 2'b01) && (off_q == 2'd3)) ||
                  ((sel_q == 3'b010) && (off_q != 2'd0));
        illegal = (sel_q == 3'b011) || (sel_q == 3'b110) || (sel_q == 3'b111);
    end

    // Next-state and datapath updates. load_data is registered on the edge
    // that enters DONE (straight from mem_RD_word for the final word), so the
    // new value is already presented during the DONE cycle alongside load_valid
    // instead of trailing it by one cycle.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        off_d       = off_q;
        mem_ra_d    = mem_ra_q;
        lo_d        = lo_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    sel_d    = load_sel;
                    off_d    = load_addr[1:0];
                    mem_ra_d = WORD_AW'(load_addr[BYTE_AW-1:2]);
                    state_d  = READ_LO;
                end
            end
            READ_LO: begin
                lo_d = mem_RD_word;
                if (split) begin
                    mem_ra_d = mem_ra_q + WORD_AW'(1);
                    state_d  = READ_HI;
                end else begin
                    load_data_d = extract(sel_q, off_q, {32'h0, mem_RD_word});
                    state_d     = DONE;
                end
            end
            READ_HI: begin
                load_data_d = extract(sel_q, off_q, {mem_RD_word, lo_q});
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            off_q       <= '0;
            mem_ra_q    <= '0;
            lo_q        <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            off_q       <= off_d;
            mem_ra_q    <= mem_ra_d;
            lo_q        <= lo_d;
            load_data_q <= load_data_d;
        end
    end

    // Status and result outputs.
    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        mem_RA     = mem_ra_q;
        load_data  = load_data_q;
        load_valid = (state_q == DONE);
        load_err   = (state_q == DONE) && illegal;
    end

endmodule

// File: tb/tb_dmem_load_unit.sv
// Self-checking bench for dmem_load_unit: table-driven loads with a
// scoreboard of expected results, plus hand sequences for back-to-back
// requests and reset during an in-flight split load.
module tb_dmem_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [10:0] load_addr;
    logic [2:0]  load_sel;
    logic        req_ready;
    logic        busy;
    logic [8:0]  mem_RA;
    logic [31:0] mem_RD_word;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_err;

    logic [31:0] mem [0:511];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [10:0] addr;
        logic [31:0] data;
        logic        err;
        int          lat;
        logic [8:0]  ra0;
        logic [8:0]  ra1;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[14];

    dmem_load_unit #(.BYTE_AW(11), .WORD_AW(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .load_addr  (load_addr),
        .load_sel   (load_sel),
        .req_ready  (req_ready),
        .busy       (busy),
        .mem_RA     (mem_RA),
        .mem_RD_word(mem_RD_word),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_RD_word = mem[mem_RA];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor: every load_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && load_err && !load_valid) begin
            checks++;
            fails++;
            $display("FAIL err_without_valid: load_err=1 load_valid=0 (cycle %0d)", cyc);
        end
        if (!rst && load_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: load_data=0x%08h with no load pending (cycle %0d)",
                         load_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("load_data", load_data, mon_e.data);
                check("load_err", {31'h0, load_err}, {31'h0, mon_e.err});
                check("valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Issue one table load from IDLE and check address/busy timing.
    task automatic run_load(input vec_t v, input int idx);
        int n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        load_sel  = v.sel;
        load_addr = v.addr;
        load_req  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_ready_timeout"}, {31'h0, req_ready}, 32'h1);
            load_req = 1'b0;
            return;
        end
        sb.push_back('{v.data, v.err, cyc + v.lat});
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                load_req = 1'b0;
                check({tag, "_mem_RA_lo"}, {23'h0, mem_RA}, {23'h0, v.ra0});
            end
            if (k == 2 && v.lat == 3)
                check({tag, "_mem_RA_hi"}, {23'h0, mem_RA}, {23'h0, v.ra1});
            check({tag, "_busy"}, {31'h0, busy}, 32'h1);
            check({tag, "_req_ready_low"}, {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_idle_ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, "_sb_drained"}, sb.size(), 32'h0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[0]   = 32'h8899AABB;
        mem[1]   = 32'h11223344;
        mem[2]   = 32'h55667788;
        mem[511] = 32'hCAFEF00D;

        //              sel     addr      data          err lat ra0 ra1
        tbl[0]  = '{3'b000, 11'h001, 32'hFFFFFFAA, 1'b0, 2, 9'd0,   9'd0};
        tbl[1]  = '{3'b100, 11'h003, 32'h00000088, 1'b0, 2, 9'd0,   9'd0};
        tbl[2]  = '{3'b001, 11'h002, 32'hFFFF8899, 1'b0, 2, 9'd0,   9'd0};
        tbl[3]  = '{3'b101, 11'h002, 32'h00008899, 1'b0, 2, 9'd0,   9'd0};
        tbl[4]  = '{3'b001, 11'h003, 32'h00004488, 1'b0, 3, 9'd0,   9'd1};
        tbl[5]  = '{3'b010, 11'h006, 32'h77881122, 1'b0, 3, 9'd1,   9'd2};
        tbl[6]  = '{3'b010, 11'h7FE, 32'hAABBCAFE, 1'b0, 3, 9'd511, 9'd0};
        tbl[7]  = '{3'b010, 11'h000, 32'h8899AABB, 1'b0, 2, 9'd0,   9'd0};
        tbl[8]  = '{3'b000, 11'h7FF, 32'hFFFFFFCA, 1'b0, 2, 9'd511, 9'd0};
        tbl[9]  = '{3'b101, 11'h7FD, 32'h0000FEF0, 1'b0, 2, 9'd511, 9'd0};
        tbl[10] = '{3'b101, 11'h7FF, 32'h0000BBCA, 1'b0, 3, 9'd511, 9'd0};
        tbl[11] = '{3'b001, 11'h005, 32'h00002233, 1'b0, 2, 9'd1,   9'd0};
        tbl[12] = '{3'b110, 11'h001, 32'h00000000, 1'b1, 2, 9'd0,   9'd0};
        tbl[13] = '{3'b000, 11'h004, 32'h00000044, 1'b0, 2, 9'd1,   9'd0};

        rst       = 1'b1;
        load_req  = 1'b0;
        load_addr = '0;
        load_sel  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_RA", {23'h0, mem_RA}, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", {31'h0, load_valid}, 32'h0);
        check("rst_load_err", {31'h0, load_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_load(tbl[i], i);

        // Illegal load held into a second request that must wait for req_ready.
        load_sel  = 3'b011;
        load_addr = 11'h000;
        load_req  = 1'b1;
        a = cyc;
        sb.push_back('{32'h0, 1'b1, a + 2});
        @(negedge clk);
        load_sel  = 3'b000;
        load_addr = 11'h001;
        check("b2b_ready_lo", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("b2b_ready_done", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("b2b_ready_again", {31'h0, req_ready}, 32'h1);
        check("b2b_accept_cycle", cyc, a + 3);
        sb.push_back('{32'hFFFFFFAA, 1'b0, cyc + 2});
        @(negedge clk);
        load_req = 1'b0;
        check("b2b_mem_RA", {23'h0, mem_RA}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("b2b_sb_drained", sb.size(), 32'h0);
        sb.delete();

        // Reset during READ_HI of a split LW: no result may come out.
        load_sel  = 3'b010;
        load_addr = 11'h001;
        load_req  = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
        check("rstmid_mem_RA_hi", {23'h0, mem_RA}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        check("rstmid_mem_RA", {23'h0, mem_RA}, 32'h0);
        check("rstmid_load_data", load_data, 32'h0);
        check("rstmid_load_valid", {31'h0, load_valid}, 32'h0);
        check("rstmid_load_err", {31'h0, load_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_still_idle", {31'h0, req_ready}, 32'h1);

        run_load('{3'b010, 11'h004, 32'h11223344, 1'b0, 2, 9'd1, 9'd0}, 100);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_load_unit.md
Name: dmem_load_unit

Overview:
- Read-side companion to the data memory's byte/half/word store path.
- Accepts one load request at a time from the MEM stage and drives the dmem word read-address port.
- Fetches one word, or two for loads that cross a word boundary.
- Extracts the addressed byte/half/word, sign- or zero-extends it, and returns it to writeback with a valid pulse; asserts busy so the hazard unit can stall the pipeline.

Parameters:
- BYTE_AW, 11, byte-address width of the load address.
- WORD_AW, 9, dmem word-address width (2^WORD_AW words).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- load_req  input  1  load request; sampled only when req_ready=1
- load_addr  input  BYTE_AW  byte address of the load
- load_sel  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- req_ready  output  1  unit idle and able to accept a request
- busy  output  1  load in flight; pipeline stall request
- mem_RA  output  WORD_AW  registered word address to the dmem combinational read port
- mem_RD_word  input  32  word returned combinationally by dmem for mem_RA
- load_data  output  32  extended load result
- load_valid  output  1  one-cycle pulse: load_data is new
- load_err  output  1  one-cycle pulse with load_valid for an illegal load_sel

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, req_ready=1, busy=0.
  - mem_RA=0, load_data=0, load_valid=0, load_err=0.
  - All internal capture registers=0.
- States: IDLE, READ_LO, READ_HI, DONE.
- req_ready = (state==IDLE); busy = (state!=IDLE).
- IDLE:
  - On load_req=1, latch sel, offset = addr[1:0], and wa = addr[BYTE_AW-1:2].
  - Set mem_RA <= wa, then go to READ_LO.
  - load_req=0 leaves all outputs at rest.
- READ_LO:
  - Capture lo <= mem_RD_word.
  - A load is split when (LH/LHU with offset==3) or (LW with offset!=0).
  - Split load: mem_RA <= wa+1, modulo 2^WORD_AW (word 511 wraps to word 0), then go to READ_HI.
  - Otherwise go to DONE.
- READ_HI: capture hi <= mem_RD_word, then go to DONE.
- DONE:
  - Form the 64-bit pair {hi,lo}, where hi=0 for unsplit loads.
  - Shift the pair right by offset*8 to give field f.
  - Register load_data from f:
    - LB: sign-extend f[7:0].
    - LBU: zero-extend f[7:0].
    - LH: sign-extend f[15:0].
    - LHU: zero-extend f[15:0].
    - LW: f[31:0].
  - Pulse load_valid=1 for this cycle only, then return to IDLE.
- Illegal sel (011, 110, 111):
  - Follows the unsplit path.
  - In DONE: load_data <= 0 and load_err=1 together with load_valid=1.
- load_data holds its value until the next DONE.
- Latency, counted from the cycle the request is accepted in IDLE:
  - Unsplit load: load_valid 2 cycles later.
  - Split load: load_valid 3 cycles later.
- Throughput: one request per 3 cycles unsplit, 4 cycles split.
- load_req while busy is ignored; the requester must hold the request until it sees req_ready.
- Reset in any state: immediately returns to IDLE with the reset values above. The in-flight load is dropped and no load_valid is produced.
- mem_RD_word is sampled only in READ_LO and READ_HI; other values are don't-care.

Test Plan:
Preload dmem word0 = 0x8899AABB, word1 = 0x11223344, word511 = 0xCAFEF00D for all cases.

1. LB addr 0x001 -> mem_RA=0; load_data=0xFFFFFFAA; load_valid pulses 2 cycles after accept; busy high 2 cycles; LBU addr 0x003 -> 0x00000088.
2. LH addr 0x002 -> 0xFFFF8899; LHU addr 0x002 -> 0x00008899; both single read, no READ_HI.
3. LH addr 0x003 (split) -> mem_RA 0 then 1; load_data=0x00004488; load_valid 3 cycles after accept.
4. LW addr 0x006 -> unsplit would be wrong; split reads word1 then word2. LW addr 0x7FE -> mem_RA 511 then 0; load_data=0xAABBCAFE.
5. load_sel=011 at addr 0x000 -> load_valid=1 with load_err=1 and load_data=0; a back-to-back request asserted during busy is not accepted until req_ready=1.
6. rst asserted during READ_HI of an LW addr 0x001 -> all outputs return to reset values asynchronously with no load_valid; a following LW addr 0x004 returns 0x11223344.
